song_select_ctrl: RTL and testbench

//  Upstream feeder of the seven-segment song display. Debounces the raw next/prev/confirm

---
 rtl/song_sel_pkg.sv | 14 +
 rtl/btn_debounce.sv | 50 +++++
 rtl/song_select_ctrl.sv | 104 ++++++++++
 tb/tb_song_select_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/song_sel_pkg.sv
// Shared definitions for the song-selection path.
// The display and the player core use the same state encoding and mode code.
package song_sel_pkg;

   localparam int          SONG_W      = 4;
   localparam logic [2:0]  MODE_SELECT = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BROWSE = 2'd1,
      ST_LOCKED = 2'd2
   } sel_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level debouncer, rising-edge press pulse.
// A level is accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_level_q;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_level_q <= 1'b0;
      end else begin
         r_s1      <= raw;
         r_s2      <= r_s1;
         r_level_q <= r_level;
         if (r_s2 != r_level) begin
            if (r_cnt == CNT_LAST) begin
               r_level <= r_s2;
               r_cnt   <= '0;
            end else begin
               r_cnt   <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign level = r_level;
   assign press = r_level & ~r_level_q;

endmodule

// File: rtl/song_select_ctrl.sv
// Song selection controller: debounced browse/confirm buttons, wrap-around song number,
// lock state and a one-cycle play_start pulse, all gated by the global mode.
module song_select_ctrl #(
   parameter int          NUM_SONGS       = 3,
   parameter int          DEBOUNCE_CYCLES = 2_000_000,
   parameter logic [2:0]  MODE_SELECT     = song_sel_pkg::MODE_SELECT
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [2:0]                      mode,
   input  logic                            btn_next,
   input  logic                            btn_prev,
   input  logic                            btn_confirm,
   output logic [song_sel_pkg::SONG_W-1:0] song_num,
   output logic                            play_start,
   output logic                            song_locked
);

   import song_sel_pkg::*;

   localparam logic [SONG_W-1:0] MAX_SONG = SONG_W'(NUM_SONGS);
   localparam logic [SONG_W-1:0] MIN_SONG = SONG_W'(1);

   logic w_next_press;
   logic w_prev_press;
   logic w_confirm_press;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_next),
      .level (),
      .press (w_next_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_prev),
      .level (),
      .press (w_prev_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirm (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_confirm),
      .level (),
      .press (w_confirm_press)
   );

   sel_state_t        r_state;
   sel_state_t        w_state_nxt;
   logic [SONG_W-1:0] r_song_num;
   logic [SONG_W-1:0] w_song_nxt;
   logic              r_play_start;
   logic              w_play_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_song_num   <= MIN_SONG;
         r_play_start <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_song_num   <= w_song_nxt;
         r_play_start <= w_play_nxt;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      w_song_nxt  = r_song_num;
      w_play_nxt  = 1'b0;
      if (mode != MODE_SELECT) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: w_state_nxt = ST_BROWSE;
            ST_BROWSE: begin
               // Confirm wins over a simultaneous browse press.
               if (w_confirm_press) begin
                  w_state_nxt = ST_LOCKED;
                  w_play_nxt  = 1'b1;
               end else if (w_next_press && !w_prev_press) begin
                  w_song_nxt = (r_song_num == MAX_SONG) ? MIN_SONG : r_song_num + 1'b1;
               end else if (w_prev_press && !w_next_press) begin
                  w_song_nxt = (r_song_num == MIN_SONG) ? MAX_SONG : r_song_num - 1'b1;
               end
            end
            ST_LOCKED: begin
               if (w_confirm_press) w_state_nxt = ST_BROWSE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign song_num    = r_song_num;
   assign play_start  = r_play_start;
   assign song_locked = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_song_select_ctrl.sv
// Directed bench for song_select_ctrl with short debounce; expected song numbers go
// through a scoreboard queue and are compared once the press has propagated.
module tb_song_select_ctrl;

   localparam int D  = 4;
   localparam int NS = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] mode;
   logic       btn_next;
   logic       btn_prev;
   logic       btn_confirm;
   logic [3:0] song_num;
   logic       play_start;
   logic       song_locked;

   int checks = 0;
   int errors = 0;
   int ps_count = 0;
   int ps_run = 0;
   int ps_run_max = 0;
   int sb_q[$];

   song_select_ctrl #(
      .NUM_SONGS       (NS),
      .DEBOUNCE_CYCLES (D),
      .MODE_SELECT     (3'b010)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mode        (mode),
      .btn_next    (btn_next),
      .btn_prev    (btn_prev),
      .btn_confirm (btn_confirm),
      .song_num    (song_num),
      .play_start  (play_start),
      .song_locked (song_locked)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (play_start) begin
         ps_count = ps_count + 1;
         ps_run   = ps_run + 1;
         if (ps_run > ps_run_max) ps_run_max = ps_run;
      end else begin
         ps_run = 0;
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold the selected buttons {confirm,prev,next} for n cycles, then let the release settle.
   task automatic press(input logic [2:0] m, input int n);
      {btn_confirm, btn_prev, btn_next} = m;
      cyc(n);
      {btn_confirm, btn_prev, btn_next} = 3'b000;
      cyc(D + 6);
   endtask

   task automatic sb_check(input string tag);
      int exp;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 1, 0);
      end else begin
         exp = sb_q.pop_front();
         check(tag, int'(song_num), exp);
      end
   endtask

   task automatic step(input string tag, input logic [2:0] m, input int exp_song);
      sb_q.push_back(exp_song);
      press(m, 6);
      sb_check(tag);
   endtask

   initial begin
      reset = 1'b1;
      mode  = 3'b000;
      {btn_confirm, btn_prev, btn_next} = 3'b000;
      cyc(2);
      check("rst_song",   int'(song_num),    1);
      check("rst_play",   int'(play_start),  0);
      check("rst_locked", int'(song_locked), 0);
      reset = 1'b0;
      mode  = 3'b010;
      cyc(1);

      // 1: latency of a held next press and single step
      sb_q.push_back(2);
      btn_next = 1'b1;
      cyc(6);
      check("lat_edge5", int'(song_num), 1);
      cyc(1);
      sb_check("lat_edge6");
      cyc(3);
      btn_next = 1'b0;
      cyc(D + 6);
      check("hold_single", int'(song_num), 2);

      // 2: wrap up and wrap down
      step("next_2to3",  3'b001, 3);
      step("next_wrap",  3'b001, 1);
      step("prev_wrap",  3'b010, 3);
      step("prev_3to2",  3'b010, 2);

      // 3: glitch rejection and simultaneous next/prev
      sb_q.push_back(2);
      press(3'b001, 3);
      sb_check("glitch");
      step("both_np", 3'b011, 2);

      // 4: confirm, lock, unlock
      ps_count   = 0;
      ps_run_max = 0;
      step("confirm_song", 3'b100, 2);
      check("confirm_pulse_cnt", ps_count, 1);
      check("confirm_pulse_len", ps_run_max, 1);
      check("locked_set", int'(song_locked), 1);
      step("next_locked", 3'b001, 2);
      step("unlock_song", 3'b100, 2);
      check("unlock_locked", int'(song_locked), 0);
      check("unlock_no_pulse", ps_count, 1);
      step("relock_song", 3'b100, 2);
      check("relock_locked", int'(song_locked), 1);
      check("relock_pulse", ps_count, 2);

      // 5: leaving select mode while locked
      mode = 3'b000;
      cyc(1);
      check("idle_unlocked", int'(song_locked), 0);
      check("idle_song", int'(song_num), 2);
      step("idle_next", 3'b001, 2);
      step("idle_confirm", 3'b100, 2);
      check("idle_no_lock", int'(song_locked), 0);
      check("idle_no_pulse", ps_count, 2);
      mode = 3'b010;
      cyc(1);
      step("resume_next", 3'b001, 3);
      check("resume_unlocked", int'(song_locked), 0);

      // 6: asynchronous reset mid-debounce and while locked
      btn_next = 1'b1;
      cyc(3);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_song",   int'(song_num),    1);
      check("rst_mid_locked", int'(song_locked), 0);
      check("rst_mid_play",   int'(play_start),  0);
      @(negedge clk);
      btn_next = 1'b0;
      cyc(2);
      reset = 1'b0;
      cyc(D + 6);
      check("rst_mid_after", int'(song_num), 1);
      cyc(1);
      step("post_rst_next", 3'b001, 2);
      step("post_rst_conf", 3'b100, 2);
      check("post_rst_locked", int'(song_locked), 1);
      #2 reset = 1'b1;
      #1;
      check("rst_lock_song",   int'(song_num),    1);
      check("rst_lock_locked", int'(song_locked), 0);
      check("rst_lock_play",   int'(play_start),  0);
      @(negedge clk);
      reset = 1'b0;
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
